// File: rtl/sensor_avg_bank.sv
// N-channel exponential averager: per-channel trigger/hold/accumulate lanes
// sharing one round-robin service slot per cycle.

module sensor_avg_ch #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] smpl,
    input  logic              trig,
    input  logic              seed,
    input  logic              svc,
    input  logic              clr_ovr,
    input  logic [2:0]        shift,
    output logic              pending,
    output logic [DATA_W-1:0] avg,
    output logic              avg_vld,
    output logic              overrun
);
    localparam int ACC_W = DATA_W + 5;

    logic [ACC_W-1:0]  acc, acc_upd;
    logic [DATA_W-1:0] hold;
    logic [2:0]        k;

    always_comb begin
        k = shift;
        if (shift == 3'd0)     k = 3'd1;
        else if (shift > 3'd5) k = 3'd5;
    end

    assign acc_upd = acc - (acc >> k) + ACC_W'(hold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            hold    <= '0;
            pending <= 1'b0;
            avg     <= '0;
            avg_vld <= 1'b0;
            overrun <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            if (seed) begin
                // A seed swallows both the service slot and any same-cycle trigger.
                acc     <= ACC_W'(smpl) << k;
                avg     <= smpl;
                avg_vld <= 1'b1;
                pending <= 1'b0;
            end else begin
                if (svc) begin
                    acc     <= acc_upd;
                    avg     <= DATA_W'(acc_upd >> k);
                    avg_vld <= 1'b1;
                    pending <= 1'b0;
                end
                if (trig) begin
                    hold    <= smpl;
                    pending <= 1'b1;
                end
            end
            if (!seed && trig && pending && !svc) overrun <= 1'b1;
            else if (clr_ovr)                     overrun <= 1'b0;
        end
    end
endmodule

module sensor_avg_bank #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 12,
    parameter int FAST_SIM = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] smpl,
    input  logic [NUM_CH-1:0]        mode,
    input  logic [NUM_CH-1:0]        ext_stb,
    input  logic [NUM_CH-1:0]        seed,
    input  logic [3*NUM_CH-1:0]      shift,
    input  logic                     clr_ovr,
    output logic [NUM_CH*DATA_W-1:0] avg,
    output logic [NUM_CH-1:0]        avg_vld,
    output logic [NUM_CH-1:0]        overrun
);
    localparam int TMR_W = (FAST_SIM != 0) ? 16 : 22;
    localparam int RR_W  = $clog2(NUM_CH);

    logic [TMR_W-1:0]  tmr;
    logic              tmr_full;
    logic [RR_W-1:0]   rr, pick;
    logic              any_pend;
    logic [NUM_CH-1:0] pend, grant;

    assign tmr_full = &tmr;

    // Scan downward so the last hit is the first pending channel at or after rr.
    always_comb begin
        grant    = '0;
        any_pend = 1'b0;
        pick     = rr;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            if (pend[RR_W'((int'(rr) + off) % NUM_CH)]) begin
                pick     = RR_W'((int'(rr) + off) % NUM_CH);
                any_pend = 1'b1;
            end
        end
        if (any_pend) grant[pick] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
            rr  <= '0;
        end else begin
            tmr <= tmr + 1'b1;
            if (any_pend) rr <= (int'(pick) == NUM_CH - 1) ? '0 : pick + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sensor_avg_ch #(.DATA_W(DATA_W)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .smpl    (smpl[i*DATA_W +: DATA_W]),
            .trig    (mode[i] ? ext_stb[i] : tmr_full),
            .seed    (seed[i]),
            .svc     (grant[i]),
            .clr_ovr (clr_ovr),
            .shift   (shift[i*3 +: 3]),
            .pending (pend[i]),
            .avg     (avg[i*DATA_W +: DATA_W]),
            .avg_vld (avg_vld[i]),
            .overrun (overrun[i])
        );
    end
endmodule

// File: tb/tb_sensor_avg_bank.sv
// Bench for sensor_avg_bank: directed scenarios plus random traffic, all
// checked cycle by cycle against an arithmetic reference of the averaging rules.

module tb_sensor_avg_bank;
    localparam int N = 4;
    localparam int W = 12;
    localparam int TMAX = 65535;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [N*W-1:0] smpl = '0;
    logic [N-1:0]   mode = '0, ext_stb = '0, seed = '0;
    logic [3*N-1:0] shift = '0;
    logic           clr_ovr = 1'b0;
    logic [N*W-1:0] avg;
    logic [N-1:0]   avg_vld, overrun;

    int n_asrt = 0;
    int n_fail = 0;

    int m_acc[N], m_hold[N], m_avg[N];
    bit m_pend[N], m_ovr[N], m_vld[N];
    int m_tmr, m_rr;

    always #5 clk = ~clk;

    sensor_avg_bank #(.NUM_CH(N), .DATA_W(W), .FAST_SIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .smpl(smpl), .mode(mode), .ext_stb(ext_stb),
        .seed(seed), .shift(shift), .clr_ovr(clr_ovr),
        .avg(avg), .avg_vld(avg_vld), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int kof(input int i);
        int s;
        s = int'(shift[i*3 +: 3]);
        if (s < 1) return 1;
        if (s > 5) return 5;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0; m_hold[i] = 0; m_avg[i] = 0;
            m_pend[i] = 0; m_ovr[i] = 0; m_vld[i] = 0;
        end
        m_tmr = 0; m_rr = 0;
    endtask

    // One clock edge of the averaging rules, using the inputs present at the edge.
    task automatic model_step();
        int c;
        bit tfull;
        c = -1;
        tfull = (m_tmr == TMAX);
        for (int off = 0; off < N; off++)
            if (c < 0 && m_pend[(m_rr + off) % N]) c = (m_rr + off) % N;
        for (int i = 0; i < N; i++) begin
            int k, x;
            bit trig, ovset;
            k = kof(i);
            x = int'(smpl[i*W +: W]);
            trig = mode[i] ? ext_stb[i] : tfull;
            ovset = !seed[i] && trig && m_pend[i] && (i != c);
            m_vld[i] = 0;
            if (seed[i]) begin
                m_acc[i] = x * (1 << k);
                m_avg[i] = x;
                m_vld[i] = 1;
                m_pend[i] = 0;
            end else begin
                if (i == c) begin
                    m_acc[i] = m_acc[i] - m_acc[i] / (1 << k) + m_hold[i];
                    m_avg[i] = (m_acc[i] / (1 << k)) % (1 << W);
                    m_vld[i] = 1;
                    m_pend[i] = 0;
                end
                if (trig) begin
                    m_hold[i] = x;
                    m_pend[i] = 1;
                end
            end
            if (ovset) m_ovr[i] = 1;
            else if (clr_ovr) m_ovr[i] = 0;
        end
        if (c >= 0) m_rr = (c + 1) % N;
        m_tmr = (m_tmr + 1) % (TMAX + 1);
    endtask

    function automatic logic [N*W-1:0] exp_avg();
        logic [N*W-1:0] e;
        for (int i = 0; i < N; i++) e[i*W +: W] = W'(m_avg[i]);
        return e;
    endfunction

    function automatic logic [N-1:0] exp_bits(input bit b[N]);
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) e[i] = b[i];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("avg", avg, exp_avg());
        chk("avg_vld", avg_vld, exp_bits(m_vld));
        chk("overrun", overrun, exp_bits(m_ovr));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_avg", avg, '0);
        chk("rst_vld", avg_vld, '0);
        chk("rst_ovr", overrun, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_smpl(input int i, input int v);
        smpl[i*W +: W] = W'(v);
    endtask

    task automatic set_shift(input int i, input int v);
        shift[i*3 +: 3] = 3'(v);
    endtask

    initial begin
        #2;
        do_reset();

        // Seed ch0 with 0x800, k=4
        set_shift(0, 4); set_smpl(0, 'h800); seed = 4'b0001;
        step();
        chk("seed_avg0", avg[11:0], 'h800);
        chk("seed_vld", avg_vld, 4'b0001);
        chk("seed_acc0", dut.g_ch[0].u_ch.acc, 'h8000);
        seed = '0;
        step();
        chk("seed_vld_off", avg_vld, 4'b0000);

        // External strobe on ch1, k=2
        mode = 4'b1111; set_shift(1, 2); set_smpl(1, 'h400); ext_stb = 4'b0010;
        step();
        ext_stb = '0;
        step();
        chk("ext1_avg", avg[23:12], 'h100);
        chk("ext1_vld", avg_vld, 4'b0010);
        ext_stb = 4'b0010;
        step();
        ext_stb = '0;
        step();
        chk("ext2_acc", dut.g_ch[1].u_ch.acc, 'h700);
        chk("ext2_avg", avg[23:12], 'h1C0);

        // Round robin from rr=2 with all four pending at once
        smpl = {$urandom, $urandom};
        ext_stb = 4'b1111;
        step();
        chk("rr_none", avg_vld, 4'b0000);
        ext_stb = '0;
        step(); chk("rr_ch2", avg_vld, 4'b0100);
        step(); chk("rr_ch3", avg_vld, 4'b1000);
        step(); chk("rr_ch0", avg_vld, 4'b0001);
        step(); chk("rr_ch1", avg_vld, 4'b0010);

        // Overrun: ch0/ch1 hold the slot while ch2 is strobed twice
        ext_stb = 4'b0011;
        step();
        set_smpl(2, 'h100); ext_stb = 4'b0101;
        step();
        set_smpl(2, 'h200); ext_stb = 4'b0100;
        step();
        chk("ovr_set", overrun, 4'b0100);
        ext_stb = '0;
        step();
        chk("ovr_svc_ch2", avg_vld, 4'b0100);
        step();
        chk("ovr_no_ch2", avg_vld[2], 1'b0);
        clr_ovr = 1'b1;
        step();
        chk("ovr_clr", overrun, 4'b0000);
        clr_ovr = 1'b0;

        // Full-scale convergence at k=5
        do_reset();
        mode = 4'b1111; shift = '0; set_shift(0, 5); set_smpl(0, 'hFFF); ext_stb = 4'b0001;
        repeat (2000) step();
        ext_stb = '0;
        step();
        chk("fs_acc", dut.g_ch[0].u_ch.acc, 'h1FFE0);
        chk("fs_avg", avg[11:0], 'hFFF);
        seed = 4'b0001;
        step();
        chk("fs_seed_acc", dut.g_ch[0].u_ch.acc, 'h1FFE0);
        chk("fs_seed_avg", avg[11:0], 'hFFF);
        seed = '0;

        // Random traffic, with an asynchronous reset dropped in mid-stream
        for (int n = 0; n < 400; n++) begin
            mode = 4'($urandom); ext_stb = 4'($urandom);
            seed = 4'($urandom & $urandom & $urandom);
            shift = 12'($urandom); smpl = {$urandom, $urandom};
            clr_ovr = ($urandom_range(0, 9) == 0);
            step();
            if (n == 200) do_reset();
        end
        mode = '0; ext_stb = '0; seed = '0; clr_ovr = 1'b0; shift = '0;

        // Periodic trigger on all channels; seed on ch3 in the trigger cycle
        do_reset();
        begin
            int early;
            early = 0;
            for (int n = 1; n <= TMAX; n++) begin
                step();
                if (avg_vld != '0) early++;
            end
            chk("per_early_vld", early, 0);
        end
        set_smpl(3, 'hABC); seed = 4'b1000;
        step();
        chk("per_seed3_vld", avg_vld, 4'b1000);
        chk("per_seed3_avg", avg[47:36], 'hABC);
        seed = '0;
        step(); chk("per_burst_ch0", avg_vld, 4'b0001);
        step(); chk("per_burst_ch1", avg_vld, 4'b0010);
        step(); chk("per_burst_ch2", avg_vld, 4'b0100);
        step(); chk("per_burst_end", avg_vld, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/sensor_avg_bank.md
# sensor_avg_bank

Parametrised N-channel exponential-average engine for the sensor-conditioning path. It replaces the fixed two-filter arrangement: one averager per sensor (current, torque, and future channels), each triggered by a free-running sample timer or an external strobe such as a cadence rise. All channels share one arithmetic unit, scheduled round-robin. Outputs feed the desired-drive and telemetry blocks.

## Interface
- NUM_CH, 4, number of channels (2..8)
- DATA_W, 12, sample and average width (unsigned)
- FAST_SIM, 1, sample-timer width: 16 bits if 1, 22 bits if 0
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- smpl  in  NUM_CH*DATA_W  raw samples; channel i is bits [i*DATA_W +: DATA_W]
- mode  in  NUM_CH  per channel: 0 = periodic trigger, 1 = ext_stb trigger
- ext_stb  in  NUM_CH  trigger pulses; each high cycle is one trigger (mode=1 only)
- seed  in  NUM_CH  pulse: load the accumulator directly from the sample
- shift  in  3*NUM_CH  per-channel weight exponent k; weight is (2^k-1)/2^k
- clr_ovr  in  1  clears all overrun flags
- avg  out  NUM_CH*DATA_W  registered averages
- avg_vld  out  NUM_CH  one-cycle pulse when avg[i] is updated
- overrun  out  NUM_CH  sticky flag: trigger lost to coalescing

## Operation
- Per-channel state:
  - acc, DATA_W+5 bits
  - hold, DATA_W bits
  - pending, 1 bit
  - overrun, 1 bit
- Shared state: sample timer; round-robin pointer rr, log2(NUM_CH) bits.
- Effective k = clamp(shift[i], 1, 5). A shift value of 0 is treated as 1; values 6 and 7 are treated as 5. A change of shift does not rescale acc; it takes effect at the next update or seed.
- Sample timer: free-running, wraps. When it is all-ones, every channel with mode=0 triggers.
- Trigger on channel i: hold[i] <= smpl[i]; pending[i] <= 1.
  - If pending[i] is already set and channel i is not being serviced this cycle, set overrun[i]. The newest sample wins; only one update results.
- Service: each cycle, pick the first pending channel at or after rr, modulo NUM_CH. For the picked channel c:
  - acc[c] <= acc[c] - (acc[c] >> k) + hold[c]
  - avg[c] <= new acc[c] >> k, low DATA_W bits
  - avg_vld[c] <= 1
  - pending[c] cleared
  - rr <= c+1, modulo NUM_CH
  - If no channel is pending, no update occurs and rr holds.
- A trigger on channel c in the same cycle it is serviced: the service uses the old hold; the new sample is written to hold and pending stays set. No overrun.
- Seed on channel i:
  - acc[i] <= smpl[i] << k; avg[i] <= smpl[i]; avg_vld[i] <= 1
  - pending[i] cleared; any same-cycle trigger on i is discarded
  - Seed takes precedence over service. If the arbiter picks i in that cycle, the slot is consumed and rr advances.
- clr_ovr clears all overrun bits. A new overrun in the same cycle wins (the flag stays set).
- The accumulator cannot overflow. Steady state for a full-scale input is (2^DATA_W - 1)·2^k ≤ 2^(DATA_W+5) - 32.

## Timing
- Reset state:
  - acc, hold, pending, overrun all 0
  - avg = 0, avg_vld = 0
  - rr = 0, timer = 0
- Trigger sampled at edge T: pending visible after T. The earliest service is at edge T+1, where avg and avg_vld update together.
  - Latency is 1 cycle minimum and NUM_CH cycles maximum when all channels are pending.
- Seed sampled at edge T: avg and avg_vld update at edge T (zero-cycle latency to the registered output).
- avg_vld is high for exactly one cycle per update or seed. avg holds its value between updates.
- Periodic trigger: first at cycle 2^16-1 after reset (FAST_SIM=1), then every 2^16 cycles.
- Reset asserted mid-operation: all state clears immediately and pending updates are lost.

## Test plan
- Seed: reset, then seed[0] with smpl0=0x800 and shift0=4. Required: acc0=0x8000, avg0=0x800, avg_vld[0] high for one cycle, no other vld.
- External update: set mode1=1, shift1=2, acc1=0; strobe with smpl1=0x400. Required: avg1=0x100 one cycle later. Strobe again with 0x400. Required: acc1=0x700, avg1=0x1C0.
- Round-robin: set rr to 2; strobe all four channels in the same cycle. Required: avg_vld pulses on ch2, ch3, ch0, ch1 in consecutive cycles (latencies 1–4).
- Overrun: hold ch0 and ch1 pending, then strobe ch2 in two consecutive cycles with 0x100 then 0x200. Required: overrun[2]=1 and a single ch2 update using 0x200. Pulse clr_ovr. Required: overrun=0.
- Periodic and timing: FAST_SIM=1, mode=0 on all channels. Required: the first avg_vld burst starts at cycle 65536 after reset; a seed on ch3 in the same cycle preempts its trigger.
- Full scale: shift=5 with a constant 0xFFF input for 2000 triggers. Required: acc converges to 0x1FFE0 with no overflow, and avg=0xFFF. A seed with 0xFFF gives the same acc immediately.
